// File: rtl/fft_spi_pkg.sv
// Shared definitions for the FFT result SPI link (transmitter and receiver).
package fft_spi_pkg;

    localparam int unsigned FFT_N           = 32;
    localparam int unsigned SPI_WORD_W      = 8;
    localparam int unsigned SPI_GAP_TIMEOUT = 1024;

    // SPI mode 0, MSB first
    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        GAP  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect register for one SPI pin.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_c  = sync_q & ~prev_q;
    assign fall_c  = ~sync_q & prev_q;

endmodule

// File: rtl/fft_spi_in.sv
// SPI mode-0 slave receiver: assembles 2*N words into a double-buffered frame.
// Optional mid-frame CS-high gap timeout enabled by FFT_SPI_IN_TIMEOUT_EN.
module fft_spi_in
    import fft_spi_pkg::*;
#(
    parameter int unsigned N     = FFT_N,
    parameter int unsigned MSB_2 = SPI_WORD_W
`ifdef FFT_SPI_IN_TIMEOUT_EN
    , parameter int unsigned GAP_TIMEOUT = SPI_GAP_TIMEOUT
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclk,
    input  logic                   mosi,
    input  logic                   cs,
    output logic [N*2*MSB_2-1:0]   data_bus,
    output logic [MSB_2-1:0]       word_out,
    output logic                   word_valid,
    output logic                   frame_valid,
    output logic                   frame_error
);

    localparam int unsigned WORDS = 2 * N;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned CNT_W = $clog2(MSB_2 + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MSB_2);
`ifdef FFT_SPI_IN_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
    logic [GAP_W-1:0] gap_cnt_q;
`endif

    logic sclk_lvl_unused;
    logic sclk_fall_unused;
    logic sclk_rise;
    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;
    logic mosi_meta_q;
    logic mosi_sync_q;

    rx_state_e            state_q;
    logic [MSB_2-1:0]     shift_q;
    logic [MSB_2-1:0]     shift_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [IDX_W-1:0]     word_idx_q;
    logic [IDX_W-1:0]     word_idx_d;
    logic [MSB_2-1:0]     word_out_q;
    logic                 word_valid_q;
    logic                 frame_valid_q;
    logic                 frame_error_q;
    logic                 frame_done_q;
    logic [WORDS*MSB_2-1:0] data_bus_q;
    logic [WORDS*MSB_2-1:0] buf_flat_c;
    logic [MSB_2-1:0]     buf_q [WORDS];
    logic                 word_done_c;
    logic                 shift_en_c;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (sclk),
        .level_o (sclk_lvl_unused),
        .rise_c  (sclk_rise),
        .fall_c  (sclk_fall_unused)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (cs),
        .level_o (cs_lvl),
        .rise_c  (cs_rise),
        .fall_c  (cs_fall)
    );

    // mosi is stable around sclk rise, so it needs no edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign word_done_c = (bit_cnt_q == FULL_CNT);
    assign shift_en_c  = (state_q == RECV) && sclk_rise && !cs_lvl;
    assign shift_d     = {shift_q[MSB_2-2:0], mosi_sync_q};

    always_comb begin
        word_idx_d = word_idx_q + IDX_W'(1);
        if (word_idx_q == LAST_IDX) begin
            word_idx_d = '0;
        end
    end

    // Working buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (word_done_c) begin
            buf_q[word_idx_q] <= shift_q;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_flat
        assign buf_flat_c[g*MSB_2 +: MSB_2] = buf_q[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            word_idx_q    <= '0;
            word_out_q    <= '0;
            word_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            frame_done_q  <= 1'b0;
            data_bus_q    <= '0;
`ifdef FFT_SPI_IN_TIMEOUT_EN
            gap_cnt_q     <= '0;
`endif
        end else begin
            word_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            frame_done_q  <= 1'b0;

            // Publish one cycle after the last word lands in the working buffer
            if (frame_done_q) begin
                data_bus_q    <= buf_flat_c;
                frame_valid_q <= 1'b1;
            end

            if (word_done_c) begin
                word_out_q   <= shift_q;
                word_valid_q <= 1'b1;
                word_idx_q   <= word_idx_d;
                frame_done_q <= (word_idx_q == LAST_IDX);
                bit_cnt_q    <= '0;
            end

            if (shift_en_c) begin
                shift_q   <= shift_d;
                bit_cnt_q <= word_done_c ? CNT_W'(1) : bit_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                IDLE: begin
                    word_idx_q <= '0;
                    bit_cnt_q  <= '0;
                    if (cs_fall) begin
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (cs_rise) begin
                        if ((bit_cnt_q != '0) && !word_done_c) begin
                            frame_error_q <= 1'b1;
                            word_idx_q    <= '0;
                            bit_cnt_q     <= '0;
                            state_q       <= IDLE;
                        end else begin
                            state_q <= GAP;
`ifdef FFT_SPI_IN_TIMEOUT_EN
                            gap_cnt_q <= '0;
`endif
                        end
                    end
                end
                GAP: begin
                    if (cs_fall) begin
                        state_q <= RECV;
`ifdef FFT_SPI_IN_TIMEOUT_EN
                        gap_cnt_q <= '0;
`endif
                    end else if (word_idx_q == '0) begin
                        state_q <= IDLE;
`ifdef FFT_SPI_IN_TIMEOUT_EN
                    end else if (gap_cnt_q == GAP_LAST) begin
                        frame_error_q <= 1'b1;
                        word_idx_q    <= '0;
                        state_q       <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_bus    = data_bus_q;
    assign word_out    = word_out_q;
    assign word_valid  = word_valid_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;

endmodule
